// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the serial PE controller: FSM encoding, PE control
// bit positions, SRAM read latency and the issue-side tag carried to the PE.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned CTL_W     = 2;
  localparam int unsigned CTL_FIRST = 0;
  localparam int unsigned CTL_LAST  = 1;
  localparam int unsigned RD_LAT    = 1;

  // Per-element control captured at issue time, delayed to meet read data.
  typedef struct packed {
    logic             vld;
    logic [CTL_W-1:0] ctl;
  } issue_tag_t;

endpackage

// File: rtl/serial_pe_ctrl.sv
// Sequences one serial PE through a fully-connected layer: streams vec_len
// (neuron, weight) pairs per output from two single-port SRAMs, marks the
// first/last element for the PE and writes each finished sum to the output
// buffer.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start/busy/done     layer handshake with the top controller
//   vec_len, out_num    layer shape, sampled on an accepted start
//   nram_*/wram_*       neuron / weight SRAM read ports (latency RD_LAT)
//   pe_*                PE operand, control and result interface
//   out_we/addr/data    output buffer write port
module serial_pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned LEN_W = 10,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned NA_W  = 10,
  parameter int unsigned WA_W  = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [OUT_W-1:0] out_num,
  output logic             busy,
  output logic             done,
  output logic             nram_en,
  output logic [NA_W-1:0]  nram_addr,
  input  logic [DW-1:0]    nram_rdata,
  output logic             wram_en,
  output logic [WA_W-1:0]  wram_addr,
  input  logic [DW-1:0]    wram_rdata,
  output logic [DW-1:0]    pe_neuron,
  output logic [DW-1:0]    pe_weight,
  output logic [CTL_W-1:0] pe_ctl,
  output logic             pe_vld_i,
  input  logic [31:0]      pe_result,
  input  logic             pe_vld_o,
  output logic             out_we,
  output logic [OUT_W-1:0] out_addr,
  output logic [31:0]      out_data
);

  state_t           state;
  logic [LEN_W-1:0] len_q, i;
  logic [OUT_W-1:0] num_q, o;
  logic [WA_W-1:0]  w;
  logic             last_elem_c, last_out_c, last_write_c;
  issue_tag_t       tag_c, tag_q;

  assign last_elem_c  = (i == len_q - LEN_W'(1));
  assign last_out_c   = (o == num_q - OUT_W'(1));
  assign last_write_c = out_we && (out_addr == num_q - OUT_W'(1));

  // Issue counters double as SRAM addresses; w walks the row-major weights.
  assign nram_addr = NA_W'(i);
  assign wram_addr = w;

  // Control for the element issued this cycle; zero when nothing is issued.
  always_comb begin
    tag_c                = '0;
    tag_c.vld            = nram_en;
    tag_c.ctl[CTL_FIRST] = nram_en && (i == '0);
    tag_c.ctl[CTL_LAST]  = nram_en && last_elem_c;
  end

  // Delay issue control by the SRAM read latency.
  if (RD_LAT <= 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_q <= '0;
      else        tag_q <= tag_c;
    end
  end else begin : g_latn
    localparam int unsigned TW = $bits(issue_tag_t);
    logic [RD_LAT*TW-1:0] sr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr <= '0;
      else        sr <= {sr[(RD_LAT-1)*TW-1:0], tag_c};
    end
    assign tag_q = sr[RD_LAT*TW-1 -: TW];
  end

  assign pe_vld_i = tag_q.vld;
  assign pe_ctl   = tag_q.ctl;

  // Operands only presented while valid so the PE port is quiet otherwise.
  assign pe_neuron = pe_vld_i ? nram_rdata : '0;
  assign pe_weight = pe_vld_i ? wram_rdata : '0;

  assign out_we   = pe_vld_o;
  assign out_data = pe_result;

  // Layer sequencer with registered handshake and read enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      num_q    <= '0;
      i        <= '0;
      o        <= '0;
      w        <= '0;
      nram_en  <= 1'b0;
      wram_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_addr <= '0;
    end else begin
      done <= 1'b0;
      if (out_we) out_addr <= out_addr + OUT_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= vec_len;
            num_q    <= out_num;
            i        <= '0;
            o        <= '0;
            w        <= '0;
            out_addr <= '0;
            if ((vec_len == '0) || (out_num == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              nram_en <= 1'b1;
              wram_en <= 1'b1;
            end
          end
        end
        RUN: begin
          w <= w + WA_W'(1);
          if (last_elem_c) begin
            i <= '0;
            o <= o + OUT_W'(1);
            if (last_out_c) begin
              state   <= DRAIN;
              nram_en <= 1'b0;
              wram_en <= 1'b0;
            end
          end else begin
            i <= i + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (last_write_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_pe_ctrl.md
Name: serial_pe_ctrl

Overview:
- Sequences one serial_pe through a fully-connected layer: for each of OUT_NUM output neurons, streams VEC_LEN (neuron, weight) pairs from two single-port SRAMs into the PE.
- Drives the PE's first/last control bits and writes each finished 32-bit partial sum to the output buffer.
- Sits between the layer-level top controller (start/done) and the PE datapath.

Parameters:
- DW, 16, neuron/weight data width (signed)
- LEN_W, 10, width of vec_len; max vector length 2^LEN_W-1
- OUT_W, 8, width of out_num and output address
- NA_W, 10, neuron SRAM address width (>= LEN_W)
- WA_W, 18, weight SRAM address width (>= LEN_W+OUT_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a layer; ignored while busy
- vec_len  in  LEN_W  elements per dot product, sampled on accepted start
- out_num  in  OUT_W  number of output neurons, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of layer
- nram_en  out  1  neuron SRAM read enable
- nram_addr  out  NA_W  neuron SRAM address
- nram_rdata  in  DW  neuron read data, valid one cycle after nram_en
- wram_en  out  1  weight SRAM read enable
- wram_addr  out  WA_W  weight SRAM address
- wram_rdata  in  DW  weight read data, valid one cycle after wram_en
- pe_neuron  out  DW  to PE neuron
- pe_weight  out  DW  to PE weight
- pe_ctl  out  2  to PE ctl; [0]=first element, [1]=last element
- pe_vld_i  out  1  to PE vld_i
- pe_result  in  32  from PE result
- pe_vld_o  in  1  from PE vld_o
- out_we  out  1  output buffer write enable
- out_addr  out  OUT_W  output buffer address
- out_data  out  32  output buffer write data

Behaviour:
- Clocking/reset: single clock clk; rst_n asynchronous, active-low. During reset all outputs are 0, state=IDLE, counters=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches vec_len/out_num and clears counters i (element), o (output), w (weight address). If either latched value is 0, go to DONE (no SRAM reads, no writes); otherwise go to RUN.
  - RUN: each cycle assert nram_en=wram_en=1, nram_addr=i, wram_addr=w; then w++ and i++. When i=vec_len-1, wrap i to 0 and increment o. After issuing (i=vec_len-1, o=out_num-1), go to DRAIN.
  - DRAIN: wait until the write for output out_num-1 has occurred, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- busy=1 in RUN and DRAIN only.
- SRAM-to-PE alignment (read latency 1):
  - pe_neuron=nram_rdata and pe_weight=wram_rdata, combinational pass-through.
  - pe_vld_i, pe_ctl[0] (i==0) and pe_ctl[1] (i==vec_len-1) are registered from the issue cycle, so they align with read data.
  - pe_ctl=0 whenever pe_vld_i=0.
  - vec_len=1: pe_ctl=2'b11 on every element.
- Writeback:
  - out_we=pe_vld_o; out_data=pe_result, combinational.
  - out_addr = write counter, incremented on each out_we and cleared on start.
  - Back-to-back outputs are legal: the next output's first element reaches the PE in the same cycle as the previous pe_vld_o. The PE overwrites its psum at the following edge, so the write sees the final value.
- Latency: with start accepted at cycle 0, issue occurs in cycles 1..L*M (L=vec_len, M=out_num).
  - Output k is written at cycle (k+1)*L+2.
  - done pulses at cycle L*M+3.
  - Total layer time is L*M+3 cycles, with no bubbles between outputs.
- Weight layout: row-major, wram_addr = o*vec_len + i, produced by incrementing w, not by a multiplier.
- start while busy or in DONE: ignored, with no effect on the latched config.
- Arithmetic: all counters unsigned; no overflow handling needed within the parameter ranges. Accumulation width is owned by the PE.

Decomposition:
- Shared package pe_ctrl_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3);
  - the PE ctl bit indices (CTL_FIRST=0, CTL_LAST=1);
  - the SRAM read latency constant RD_LAT=1.
- Sub-module: none required. The issue-side address generator (i/o/w counters) may be split out as pe_addr_gen if preferred.
- The bench instantiates serial_pe and two behavioural SRAMs.

Test Plan:
- Basic dot product:
  - Stimulus: vec_len=4, out_num=1; neurons {1,2,3,4}; weights {5,6,7,8}; start.
  - Required: one out_we at cycle 6 with out_addr=0, out_data=70; done at cycle 7.
- Back-to-back outputs:
  - Stimulus: vec_len=3, out_num=3; neurons {1,1,1}; weight rows {1,2,3},{-1,-1,-1},{100,0,0}.
  - Required: writes {6,-3,100} at cycles 5,8,11 to addrs 0,1,2; wram_addr sequence 0..8; done at cycle 12.
- Length-1 edge case:
  - Stimulus: vec_len=1, out_num=2; neuron {-7}; weights {3,-3}.
  - Required: pe_ctl=2'b11 on both elements; writes -21 then 21 on consecutive cycles.
- Zero config:
  - Stimulus: out_num=0 (separately, vec_len=0).
  - Required: no nram_en/wram_en/out_we; done one cycle after start; busy never 1.
- Start while busy:
  - Stimulus: pulse start with different config mid-run.
  - Required: results and write count unchanged versus an undisturbed run.
- Reset mid-run:
  - Stimulus: drop rst_n during RUN of a 4x4 layer.
  - Required: all outputs 0 immediately; after release, a new start produces correct full results with out_addr restarting at 0.
